// File: rtl/fcfs_arbiter_queue_if.sv
// Request/grant bundle between the masters and the FCFS bus arbiter.
// Ports: Start/Req toward the arbiter; Grant/GrantId/GrantValid/GrantChg/QueueCount/Ready back.
interface fcfs_arbiter_queue_if #(
    parameter int N = 8
);
    localparam int IDW = $clog2(N);

    logic           Start;
    logic [N-1:0]   Req;
    logic [N-1:0]   Grant;
    logic [IDW-1:0] GrantId;
    logic           GrantValid;
    logic           GrantChg;
    logic [IDW:0]   QueueCount;
    logic           Ready;

    modport master (
        output Start, Req,
        input  Grant, GrantId, GrantValid, GrantChg, QueueCount, Ready
    );

    modport slave (
        input  Start, Req,
        output Grant, GrantId, GrantValid, GrantChg, QueueCount, Ready
    );
endinterface

// File: rtl/fcfs_arbiter_queue.sv
// First-come-first-served bus arbiter: arrival-ordered ID queue, head holds the grant.
// Ports: Clk, Rst_n (async, active low), bus (slave side of fcfs_arbiter_queue_if).
module fcfs_arbiter_queue #(
    parameter int N = 8
) (
    input  logic                Clk,
    input  logic                Rst_n,
    fcfs_arbiter_queue_if.slave bus
);
    localparam int IDW = $clog2(N);

    typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;

    state_t         state, state_n;
    logic [IDW-1:0] q   [N];
    logic [IDW-1:0] q_n [N];
    logic [IDW:0]   cnt, cnt_n;
    logic [N-1:0]   inq, inq_n;
    logic           chg, chg_n;

    logic [N-1:0]   w, a;
    logic [IDW-1:0] rm_id, rm_pos, a_id;
    logic           gv, gv_n;
    logic [IDW-1:0] gid, gid_n;

    function automatic logic [IDW-1:0] lowest_id(input logic [N-1:0] v);
        logic [IDW-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--)
            if (v[i]) r = IDW'(i);
        return r;
    endfunction

    always_comb begin
        state_n = state;
        q_n     = q;
        cnt_n   = cnt;
        inq_n   = inq;
        w       = inq & ~bus.Req;
        a       = bus.Req & ~inq;
        rm_id   = '0;
        rm_pos  = '0;
        a_id    = lowest_id(a);

        unique case (state)
            IDLE:    if (bus.Start)  state_n = INIT;
            INIT:    if (!bus.Start) state_n = RUN;
            RUN:     if (bus.Start)  state_n = INIT;
            default: state_n = IDLE;
        endcase

        if (state_n == INIT) begin
            // Flush on every edge that lands in INIT, including RUN->INIT.
            for (int i = 0; i < N; i++) q_n[i] = '0;
            cnt_n = '0;
            inq_n = '0;
        end else if (state == RUN) begin
            if (w != '0) begin
                // w non-zero implies a non-empty queue, so q[0] is valid.
                rm_id = w[q[0]] ? q[0] : lowest_id(w);
                for (int i = 0; i < N; i++)
                    if ((IDW+1)'(i) < cnt && q[i] == rm_id)
                        rm_pos = IDW'(i);
                for (int i = 0; i < N - 1; i++)
                    if (IDW'(i) >= rm_pos) q_n[i] = q[i+1];
                q_n[N-1]     = '0;
                cnt_n        = cnt - (IDW+1)'(1);
                inq_n[rm_id] = 1'b0;
            end else if (a != '0) begin
                for (int i = 0; i < N; i++)
                    if ((IDW+1)'(i) == cnt) q_n[i] = a_id;
                cnt_n       = cnt + (IDW+1)'(1);
                inq_n[a_id] = 1'b1;
            end
        end

        gv    = (state == RUN) && (cnt != '0);
        gid   = gv ? q[0] : '0;
        gv_n  = (state_n == RUN) && (cnt_n != '0);
        gid_n = gv_n ? q_n[0] : '0;
        chg_n = (gv_n != gv) || (gid_n != gid);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
            for (int i = 0; i < N; i++) q[i] <= '0;
            cnt   <= '0;
            inq   <= '0;
            chg   <= 1'b0;
        end else begin
            state <= state_n;
            q     <= q_n;
            cnt   <= cnt_n;
            inq   <= inq_n;
            chg   <= chg_n;
        end
    end

    assign bus.Grant      = gv ? (N'(1) << q[0]) : '0;
    assign bus.GrantId    = gid;
    assign bus.GrantValid = gv;
    assign bus.GrantChg   = chg;
    assign bus.QueueCount = cnt;
    assign bus.Ready      = (state == RUN);
endmodule

// File: tb/tb_fcfs_arbiter_queue.sv
// Self-checking bench for fcfs_arbiter_queue against a queue-based reference model.
// Directed scenarios followed by randomized request traffic.
module tb_fcfs_arbiter_queue;
    localparam int N = 8;

    logic Clk;
    logic Rst_n;

    fcfs_arbiter_queue_if #(.N(N)) bus ();

    fcfs_arbiter_queue #(.N(N)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_chk;
    int n_pass;

    // Reference model: 0=IDLE 1=INIT 2=RUN
    int mst;
    int mq[$];
    int mchg;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int m_gv();
        return (mst == 2 && mq.size() > 0) ? 1 : 0;
    endfunction

    function automatic int m_gid();
        return m_gv() ? mq[0] : 0;
    endfunction

    function automatic int in_q(input int id);
        foreach (mq[k]) if (mq[k] == id) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        mst = 0;
        mq.delete();
        mchg = 0;
    endtask

    task automatic model_step();
        int pgv, pgid, rid, pos;
        logic [N-1:0] r;
        pgv  = m_gv();
        pgid = m_gid();
        r    = bus.Req;
        if (mst == 0) begin
            if (bus.Start) mst = 1;
        end else if (mst == 1) begin
            mq.delete();
            if (!bus.Start) mst = 2;
        end else if (bus.Start) begin
            mst = 1;
            mq.delete();
        end else begin
            rid = -1;
            if (mq.size() > 0 && !r[mq[0]]) rid = mq[0];
            else
                for (int i = N - 1; i >= 0; i--)
                    if (in_q(i) != 0 && !r[i]) rid = i;
            if (rid >= 0) begin
                pos = 0;
                foreach (mq[k]) if (mq[k] == rid) pos = k;
                mq.delete(pos);
            end else begin
                for (int i = N - 1; i >= 0; i--)
                    if (r[i] && in_q(i) == 0) rid = i;
                if (rid >= 0) mq.push_back(rid);
            end
        end
        mchg = (m_gv() != pgv || m_gid() != pgid) ? 1 : 0;
    endtask

    task automatic compare_all(input string tag);
        int g;
        g = m_gv() ? (1 << mq[0]) : 0;
        check({tag, ".grant"}, int'(bus.Grant), g);
        check({tag, ".gid"},   int'(bus.GrantId), m_gid());
        check({tag, ".gv"},    int'(bus.GrantValid), m_gv());
        check({tag, ".chg"},   int'(bus.GrantChg), mchg);
        check({tag, ".cnt"},   int'(bus.QueueCount), mq.size());
        check({tag, ".rdy"},   int'(bus.Ready), (mst == 2) ? 1 : 0);
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge Clk);
        #1;
        compare_all(tag);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".grant"}, int'(bus.Grant), 0);
        check({tag, ".gid"},   int'(bus.GrantId), 0);
        check({tag, ".gv"},    int'(bus.GrantValid), 0);
        check({tag, ".chg"},   int'(bus.GrantChg), 0);
        check({tag, ".cnt"},   int'(bus.QueueCount), 0);
        check({tag, ".rdy"},   int'(bus.Ready), 0);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        model_reset();
        Rst_n     = 1'b0;
        bus.Start = 1'b0;
        bus.Req   = 8'hFF;
        #2;
        check_zero("reset");

        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        tick("idle");
        check("idle_rdy", int'(bus.Ready), 0);

        bus.Start = 1'b1;
        bus.Req   = 8'h00;
        tick("start1");
        tick("start2");
        bus.Start = 1'b0;
        tick("run");
        check("run_rdy", int'(bus.Ready), 1);

        bus.Req = 8'h08;
        tick("single");
        check("single_grant", int'(bus.Grant), 8'h08);
        check("single_gid", int'(bus.GrantId), 3);
        check("single_cnt", int'(bus.QueueCount), 1);
        check("single_chg", int'(bus.GrantChg), 1);
        tick("single_hold");
        check("single_chg_off", int'(bus.GrantChg), 0);

        bus.Req = 8'h00;
        tick("drain");
        bus.Req = 8'h25;
        repeat (3) tick("simul");
        check("simul_cnt", int'(bus.QueueCount), 3);
        check("simul_grant", int'(bus.Grant), 8'h01);
        bus.Req = 8'h24;
        tick("simul_drop0");
        check("simul_g2", int'(bus.Grant), 8'h04);
        bus.Req = 8'h20;
        tick("simul_drop2");
        check("simul_g5", int'(bus.Grant), 8'h20);
        bus.Req = 8'h00;
        tick("drain");

        bus.Req = 8'h10;
        tick("mid_a");
        bus.Req = 8'h12;
        tick("mid_b");
        bus.Req = 8'h52;
        tick("mid_c");
        bus.Req = 8'h50;
        tick("mid_wd");
        check("mid_cnt", int'(bus.QueueCount), 2);
        check("mid_grant", int'(bus.Grant), 8'h10);
        check("mid_chg", int'(bus.GrantChg), 0);
        bus.Req = 8'h40;
        tick("mid_next");
        check("mid_g6", int'(bus.Grant), 8'h40);
        bus.Req = 8'h00;
        tick("drain");

        bus.Req = 8'hFF;
        repeat (8) tick("full");
        check("full_cnt", int'(bus.QueueCount), 8);
        bus.Start = 1'b1;
        tick("flush");
        check("flush_grant", int'(bus.Grant), 0);
        check("flush_cnt", int'(bus.QueueCount), 0);
        bus.Start = 1'b0;
        tick("reinit");
        repeat (8) tick("refill");
        check("refill_cnt", int'(bus.QueueCount), 8);
        check("refill_grant", int'(bus.Grant), 8'h01);

        bus.Req = 8'h00;
        repeat (8) tick("drain");
        bus.Req = 8'h02;
        tick("pre_rst");
        check("pre_rst_grant", int'(bus.Grant), 8'h02);
        #3;
        Rst_n = 1'b0;
        model_reset();
        #1;
        check_zero("async_rst");
        check("async_rst_g", int'(bus.Grant), 0);

        @(posedge Clk);
        #1;
        Rst_n     = 1'b1;
        bus.Start = 1'b1;
        bus.Req   = '0;
        tick("r_start");
        bus.Start = 1'b0;
        tick("r_run");

        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 5) == 0) bus.Req[b] = ~bus.Req[b];
            bus.Start = ($urandom_range(0, 59) == 0);
            tick("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
